// File: rtl/pc_next_unit.sv
// -----------------------------------------------------------------------------
// pc_next_unit
//
// Owns the MIPS program counter and selects the next fetch address from
// PC+4, a PC-relative branch target, a J/JAL region target or a JR/JALR
// register target. An optional architectural delay slot holds a taken
// redirect for one instruction before it is applied. A misaligned JR target
// traps straight to EXC_VECTOR and raises a one-cycle error pulse.
//
// Parameters
//   WIDTH       address width (28..64)
//   RESET_PC    PC loaded on reset
//   EXC_VECTOR  redirect address for a misaligned JR target
//   DELAY_SLOT  1: one delay slot after a taken redirect, 0: immediate redirect
//
// Ports
//   i_clk           system clock, rising edge
//   i_rst_n         asynchronous active-low reset
//   i_stall         hold PC and all state this cycle, ignore requests
//   i_branch_taken  resolved conditional branch is taken
//   i_branch_imm    signed word offset of the branch
//   i_jump          J/JAL request
//   i_jump_idx      26-bit instruction index of J/JAL
//   i_jump_reg      JR/JALR request
//   i_reg_target    register-supplied JR/JALR target
//   o_pc            current PC (registered)
//   o_pc_plus4      o_pc + 4
//   o_link_addr     return address: pc+8 with a delay slot, pc+4 without
//   o_slot_pending  a delay-slot redirect is latched (registered)
//   o_addr_err      one-cycle pulse after a misaligned JR target (registered)
// -----------------------------------------------------------------------------
module pc_next_unit #(
   parameter int unsigned      WIDTH      = 32,
   parameter logic [WIDTH-1:0] RESET_PC   = '0,
   parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h8000_0180),
   parameter bit               DELAY_SLOT = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_branch_taken,
   input  logic [15:0]      i_branch_imm,
   input  logic             i_jump,
   input  logic [25:0]      i_jump_idx,
   input  logic             i_jump_reg,
   input  logic [WIDTH-1:0] i_reg_target,
   output logic [WIDTH-1:0] o_pc,
   output logic [WIDTH-1:0] o_pc_plus4,
   output logic [WIDTH-1:0] o_link_addr,
   output logic             o_slot_pending,
   output logic             o_addr_err
);

   typedef enum logic [0:0] {
      StNormal,
      StSlot
   } state_e;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e           r_state;
   logic [WIDTH-1:0] r_pc;
   logic [WIDTH-1:0] r_target;
   logic             r_addr_err;

   state_e           w_state_next;
   logic [WIDTH-1:0] w_pc_next;
   logic [WIDTH-1:0] w_target_next;
   logic             w_addr_err_next;

   // ---------------------------------------------------------------------------
   // Address arithmetic (all modulo 2^WIDTH)
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] w_pc_plus4;
   logic [WIDTH-1:0] w_pc_plus8;
   logic [WIDTH-1:0] w_branch_off;
   logic [WIDTH-1:0] w_branch_target;
   logic [WIDTH-1:0] w_jump_target;

   assign w_pc_plus4 = r_pc + WIDTH'(4);
   assign w_pc_plus8 = r_pc + WIDTH'(8);

   // Word offset sign-extended and scaled to bytes.
   assign w_branch_off    = {{(WIDTH - 18){i_branch_imm[15]}}, i_branch_imm, 2'b00};
   assign w_branch_target = w_pc_plus4 + w_branch_off;

   // J/JAL stays inside the 256 MB region of the delay-slot instruction.
   if (WIDTH == 28) begin : g_jump_narrow
      assign w_jump_target = {i_jump_idx, 2'b00};
   end else begin : g_jump_wide
      assign w_jump_target = {w_pc_plus4[WIDTH-1:28], i_jump_idx, 2'b00};
   end

   // ---------------------------------------------------------------------------
   // Request decode
   // ---------------------------------------------------------------------------
   logic             w_misaligned;
   logic             w_redirect;
   logic [WIDTH-1:0] w_redirect_target;

   assign w_misaligned = i_jump_reg && (i_reg_target[1:0] != 2'b00);

   // A misaligned JR is handled as a trap, never as a redirect.
   assign w_redirect = (i_jump_reg && !w_misaligned) || i_jump || i_branch_taken;

   // Priority: jump_reg > jump > branch_taken.
   always_comb begin
      w_redirect_target = w_branch_target;
      if (i_jump_reg) begin
         w_redirect_target = i_reg_target;
      end else if (i_jump) begin
         w_redirect_target = w_jump_target;
      end
   end

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StNormal;
         r_pc       <= RESET_PC;
         r_target   <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_pc       <= w_pc_next;
         r_target   <= w_target_next;
         r_addr_err <= w_addr_err_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_next    = r_state;
      w_pc_next       = r_pc;
      w_target_next   = r_target;
      w_addr_err_next = 1'b0;

      if (!i_stall) begin
         if (w_misaligned) begin
            // Trap wins in every state and drops any latched delay-slot target.
            w_pc_next       = EXC_VECTOR;
            w_state_next    = StNormal;
            w_addr_err_next = 1'b1;
         end else begin
            unique case (r_state)
               StNormal: begin
                  if (w_redirect && DELAY_SLOT) begin
                     // Fetch the delay-slot instruction first, redirect after it.
                     w_pc_next     = w_pc_plus4;
                     w_target_next = w_redirect_target;
                     w_state_next  = StSlot;
                  end else if (w_redirect) begin
                     w_pc_next = w_redirect_target;
                  end else begin
                     w_pc_next = w_pc_plus4;
                  end
               end
               StSlot: begin
                  // Branches inside the delay slot are not supported: ignored.
                  w_pc_next    = r_target;
                  w_state_next = StNormal;
               end
               default: begin
                  w_pc_next    = w_pc_plus4;
                  w_state_next = StNormal;
               end
            endcase
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      o_pc           = r_pc;
      o_pc_plus4     = w_pc_plus4;
      o_link_addr    = DELAY_SLOT ? w_pc_plus8 : w_pc_plus4;
      o_slot_pending = DELAY_SLOT && (r_state == StSlot);
      o_addr_err     = r_addr_err;
   end

   // ---------------------------------------------------------------------------
   // Properties
   // ---------------------------------------------------------------------------
   // The error pulse always coincides with the PC sitting on the vector.
   a_err_at_vector : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      r_addr_err |-> (r_pc == EXC_VECTOR));

   // Without a delay slot the FSM never leaves NORMAL.
   a_no_slot : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !DELAY_SLOT |-> (r_state == StNormal));

   // A stalled cycle never produces an error pulse.
   a_stall_no_err : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      i_stall |=> !r_addr_err);

endmodule
